adder_tree_frame_packer: RTL

- Upstream feeder for the CSA adder tree: gathers a serial stream of DATA_W-bit samples into one packed frame of DATA_N words.
- Presents the frame on the tree's packed input bus using a valid/ready handshake.
- Double-buffered (fill buffer plus output register), so collection of the next frame overlaps presentation of the current one.
- Tracks each launched frame through the tree's pipeline and flags when the tree output belongs to it.

---
 rtl/adder_tree_pkg.sv | 10 +
 rtl/adder_tree_frame_packer_if.sv | 25 ++
 rtl/adder_tree_vdelay.sv | 30 +++
 rtl/adder_tree_frame_packer.sv | 92 +++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared defaults, frame/count types and fill-state encoding for the adder tree frame packer
package adder_tree_pkg;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_DATA_N = 9;
  localparam int DEF_TREE_LAT = 4;
  localparam int CNT_W = $clog2(DEF_DATA_N + 1);
  typedef logic [0:DEF_DATA_N-1][DEF_DATA_W-1:0] frame_t;
  typedef logic [CNT_W-1:0] count_t;
  typedef enum logic {FILL, HOLD} fill_state_e;
endpackage

// File: rtl/adder_tree_frame_packer_if.sv
// adder_tree_frame_packer_if: sample input stream and packed frame output stream
interface adder_tree_frame_packer_if
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DATA_N = DEF_DATA_N
);
  localparam int CW = $clog2(DATA_N + 1);
  logic s_valid;
  logic s_ready;
  logic s_last;
  logic [DATA_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [0:DATA_N-1][DATA_W-1:0] m_data;
  logic [CW-1:0] m_count;
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count
  );
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count
  );
endinterface

// File: rtl/adder_tree_vdelay.sv
// adder_tree_vdelay: fixed-depth shift register tracking launched frames through the tree pipeline
module adder_tree_vdelay #(
  parameter int LAT = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);
  logic [LAT-1:0] r_v;
  logic [LAT-1:0][CNT_W-1:0] r_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
    end else begin
      r_v[0] <= i_valid;
      r_c[0] <= i_valid ? i_count : '0;
      for (int k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        r_c[k] <= r_c[k-1];
      end
    end
  end
  assign o_valid = r_v[LAT-1];
  assign o_count = r_c[LAT-1];
endmodule

// File: rtl/adder_tree_frame_packer.sv
// adder_tree_frame_packer: packs serial samples into zero-padded frames for the CSA adder tree,
// double-buffered so the next frame fills while the current one waits for launch
module adder_tree_frame_packer
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DATA_N = DEF_DATA_N,
  parameter int TREE_LAT = DEF_TREE_LAT,
  localparam int CNT_W = $clog2(DATA_N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_tree_frame_packer_if.slave bus,
  output logic             o_tree_valid,
  output logic [CNT_W-1:0] o_tree_count
);
  fill_state_e r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_hold_count;
  logic [CNT_W-1:0] r_m_count;
  logic [0:DATA_N-1][DATA_W-1:0] r_fill;
  logic [0:DATA_N-1][DATA_W-1:0] r_m_data;
  logic [0:DATA_N-1][DATA_W-1:0] w_frame;
  logic r_s_ready;
  logic r_m_valid;
  logic w_acc;
  logic w_done;
  logic w_launch;
  logic w_out_free;
  logic [CNT_W-1:0] w_count;
  assign w_acc = bus.s_valid && r_s_ready;
  assign w_done = w_acc && (bus.s_last || r_idx == CNT_W'(DATA_N - 1));
  assign w_launch = r_m_valid && bus.m_ready;
  assign w_out_free = !r_m_valid || bus.m_ready;
  assign w_count = r_idx + 1'b1;
  // Completed frame: earlier words from the buffer, the closing sample, then zero padding
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < DATA_N; k++)
      w_frame[k] = CNT_W'(k) < r_idx ? r_fill[k] : CNT_W'(k) == r_idx ? bus.s_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_idx <= '0;
      r_hold_count <= '0;
      r_m_count <= '0;
      r_fill <= '0;
      r_m_data <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_launch) r_m_valid <= 1'b0;
      if (r_state == FILL) begin
        r_s_ready <= 1'b1;
        if (w_done && w_out_free) begin
          r_m_data <= w_frame;
          r_m_count <= w_count;
          r_m_valid <= 1'b1;
          r_idx <= '0;
        end else if (w_done) begin
          r_fill <= w_frame;
          r_hold_count <= w_count;
          r_idx <= '0;
          r_state <= HOLD;
          r_s_ready <= 1'b0;
        end else if (w_acc) begin
          r_fill[r_idx] <= bus.s_data;
          r_idx <= w_count;
        end
      end else if (w_launch) begin
        r_m_data <= r_fill;
        r_m_count <= r_hold_count;
        r_m_valid <= 1'b1;
        r_state <= FILL;
        r_s_ready <= 1'b1;
      end
    end
  end
  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data = r_m_data;
  assign bus.m_count = r_m_count;
  adder_tree_vdelay #(.LAT(TREE_LAT), .CNT_W(CNT_W)) u_vdelay (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(w_launch),
    .i_count(r_m_count),
    .o_valid(o_tree_valid),
    .o_count(o_tree_count)
  );
endmodule
